fp_mul_arbiter: RTL

- Shares one combinational FP32 multiplier (the team's IEEE-754 single-precision Multiplication unit, instantiated inside this block) between NUM_REQ requesters, e.g. neuron-update lanes in the SNN accelerator.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Two-stage registered pipeline (operand register, result register) with backpressure.
- Each response is tagged with the index of the requester that issued it.

---
 rtl/fp_mul_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter that shares one FP32 multiplier between
// NUM_REQ requesters. Two registered stages (operands, result) with
// valid/ready backpressure; each response carries the issuing requester index.
// Optional counters: define FP_MUL_ARB_STATS_EN to enable stat_ops/stat_exc.

// Combinational IEEE-754 single-precision multiplier.
// Inf/NaN operands raise Exception with a zero result; denormal inputs are
// treated as zero; results round to nearest even.
module fp32_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);
  logic              sign;
  logic [7:0]        ea, eb;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic              guard, sticky, rnd;
  logic [24:0]       sig_r;
  logic [22:0]       frac;
  logic signed [9:0] exp_s;

  // Significand product, normalisation, rounding and special-case selection
  always_comb begin
    sign      = a[31] ^ b[31];
    ea        = a[30:23];
    eb        = b[30:23];
    prod      = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd       = guard & (sticky | mant[0]);
    sig_r     = {2'b01, mant} + {24'd0, rnd};
    // a rounding carry leaves the fraction all-zero and bumps the exponent
    frac      = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
    exp_s     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + $signed({9'd0, prod[47]}) + $signed({9'd0, sig_r[24]});
    result    = 32'd0;
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if ((&ea) | (&eb)) begin
      exception = 1'b1;
    end else if (ea == 8'd0 || eb == 8'd0) begin
      result = {sign, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      overflow = 1'b1;
      result   = {sign, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      underflow = 1'b1;
      result    = {sign, 31'd0};
    end else begin
      result = {sign, exp_s[7:0], frac};
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic [2:0]              rsp_flags,
  output logic                    busy,
  output logic [31:0]             stat_ops,
  output logic [15:0]             stat_exc
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [ID_W-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [31:0]     result;
    logic [2:0]      flags;
    logic [ID_W-1:0] id;
  } s2_t;

  logic [NUM_REQ-1:0][31:0] op_a, op_b;
  logic [STAGES:1]          vld_pipe;
  s1_t                      s1_q;
  s2_t                      s2_q;
  logic [ID_W-1:0]          ptr_q, ptr_nxt, win_id;
  logic [NUM_REQ-1:0]       win;
  logic [ID_W:0]            idx;
  logic                     found;
  logic                     s2_stall, s1_stall, can_accept, xfer;
  logic [31:0]              mul_res;
  logic                     mul_exc, mul_ovf, mul_unf;

  assign op_a = req_a;
  assign op_b = req_b;

  assign s2_stall   = vld_pipe[2] & ~rsp_ready;
  assign s1_stall   = vld_pipe[1] & s2_stall;
  assign can_accept = ~s1_stall;

  // Rotating-priority search starting at ptr_q; first valid requester wins
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found                 = 1'b1;
        win[idx[ID_W-1:0]]    = 1'b1;
        win_id                = idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves one past the winner so it has lowest priority next time
  always_comb begin
    ptr_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  end

  // Grant is suppressed while in reset so nothing looks accepted
  assign req_ready = win & {NUM_REQ{can_accept & ~rst}};
  assign xfer      = |(req_valid & req_ready);

  fp32_mul u_mul (
    .a         (s1_q.a),
    .b         (s1_q.b),
    .result    (mul_res),
    .exception (mul_exc),
    .overflow  (mul_ovf),
    .underflow (mul_unf)
  );

  // Pipeline advance: S1 takes the granted operands, S2 takes the product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      ptr_q    <= '0;
    end else begin
      if (xfer) begin
        vld_pipe[1] <= 1'b1;
        s1_q.a      <= op_a[win_id];
        s1_q.b      <= op_b[win_id];
        s1_q.id     <= win_id;
        ptr_q       <= ptr_nxt;
      end else if (!s1_stall) begin
        vld_pipe[1] <= 1'b0;
      end
      if (!s2_stall) begin
        vld_pipe[2] <= vld_pipe[1];
        // data only loads with a real op, so idle outputs keep the last result
        if (vld_pipe[1]) begin
          s2_q.result <= mul_res;
          s2_q.flags  <= {mul_exc, mul_ovf, mul_unf};
          s2_q.id     <= s1_q.id;
        end
      end
    end
  end

  assign rsp_valid  = vld_pipe[2];
  assign rsp_id     = s2_q.id;
  assign rsp_result = s2_q.result;
  assign rsp_flags  = s2_q.flags;
  assign busy       = |vld_pipe;

`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] ops_q;
  logic [15:0] exc_q;
  logic        rsp_fire;

  assign rsp_fire = vld_pipe[2] & rsp_ready;

  // Saturating counters of completed responses and flagged responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q <= '0;
      exc_q <= '0;
    end else if (rsp_fire) begin
      if (ops_q != '1) ops_q <= ops_q + 1'b1;
      if ((|s2_q.flags) && exc_q != '1) exc_q <= exc_q + 1'b1;
    end
  end

  assign stat_ops = ops_q;
  assign stat_exc = exc_q;
`else
  assign stat_ops = '0;
  assign stat_exc = '0;
`endif

endmodule
